// File: rtl/clock_ctrl.sv
// Mode and alarm controller for digClock: sequences time-set modes, edits a BCD
// alarm time and runs the ring/snooze sequence against the live clock digits.
module clock_ctrl #(
    parameter int RING_CYCLES   = 60,
    parameter int SNOOZE_CYCLES = 300,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    input  logic       alarm_on,
    input  logic [3:0] h2,
    input  logic [3:0] h1,
    input  logic [3:0] m2,
    input  logic [3:0] m1,
    input  logic [3:0] s2,
    input  logic [3:0] s1,
    output logic       key,
    output logic       hrup,
    output logic       minup,
    output logic [3:0] al_h2,
    output logic [3:0] al_h1,
    output logic [3:0] al_m2,
    output logic [3:0] al_m1,
    output logic [2:0] mode,
    output logic       ringing
);

    typedef enum logic [2:0] {
        M_RUN     = 3'd0,
        M_SET_HR  = 3'd1,
        M_SET_MIN = 3'd2,
        M_AL_HR   = 3'd3,
        M_AL_MIN  = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        A_IDLE   = 2'd0,
        A_RING   = 2'd1,
        A_SNOOZE = 2'd2
    } al_e;

    localparam logic [CNT_W-1:0] RING_LD   = CNT_W'(RING_CYCLES);
    localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_CYCLES);

    // Two-digit BCD increment that wraps to 00 after the given top value.
    function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] val,
                                                input logic [3:0] top_hi,
                                                input logic [3:0] top_lo);
        logic [7:0] res;
        if ((val[7:4] == top_hi) && (val[3:0] == top_lo)) begin
            res = 8'h00;
        end else if (val[3:0] == 4'd9) begin
            res = {val[7:4] + 4'd1, 4'd0};
        end else begin
            res = {val[7:4], val[3:0] + 4'd1};
        end
        return res;
    endfunction

    mode_e            mode_q, mode_d;
    al_e              al_st_q, al_st_d;
    logic             key_q, key_d;
    logic             hrup_q, hrup_d;
    logic             minup_q, minup_d;
    logic             ringing_q, ringing_d;
    logic [7:0]       al_hr_q, al_hr_d;
    logic [7:0]       al_min_q, al_min_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       btn_prev_q;
    logic             match_prev_q;

    logic [3:0] btn_s;
    logic [3:0] ev_s;
    logic       mode_ev_s, inc_ev_s, stop_ev_s, snooze_ev_s;
    logic       match_s, trig_s;

    assign btn_s       = {snooze_btn, stop_btn, inc_btn, mode_btn};
    assign ev_s        = btn_s & ~btn_prev_q;
    assign mode_ev_s   = ev_s[0];
    assign inc_ev_s    = ev_s[1];
    assign stop_ev_s   = ev_s[2];
    assign snooze_ev_s = ev_s[3];

    assign match_s = alarm_on && ({h2, h1, m2, m1} == {al_hr_q, al_min_q}) &&
                     (s2 == 4'd0) && (s1 == 4'd0);
    assign trig_s  = match_s & ~match_prev_q;

    // Main mode sequencing; a mode step pre-empts a same-cycle increment.
    always_comb begin
        mode_d   = mode_q;
        hrup_d   = 1'b0;
        minup_d  = 1'b0;
        al_hr_d  = al_hr_q;
        al_min_d = al_min_q;
        if (mode_ev_s) begin
            case (mode_q)
                M_RUN:     mode_d = M_SET_HR;
                M_SET_HR:  mode_d = M_SET_MIN;
                M_SET_MIN: mode_d = M_AL_HR;
                M_AL_HR:   mode_d = M_AL_MIN;
                M_AL_MIN:  mode_d = M_RUN;
                default:   mode_d = M_RUN;
            endcase
        end else if (inc_ev_s) begin
            case (mode_q)
                M_SET_HR:  hrup_d   = 1'b1;
                M_SET_MIN: minup_d  = 1'b1;
                M_AL_HR:   al_hr_d  = bcd_inc_wrap(al_hr_q, 4'd2, 4'd3);
                M_AL_MIN:  al_min_d = bcd_inc_wrap(al_min_q, 4'd5, 4'd9);
                default:   hrup_d   = 1'b0;
            endcase
        end else begin
            mode_d = mode_q;
        end
        key_d = (mode_d != M_SET_HR) && (mode_d != M_SET_MIN);
    end

    // Alarm ring/snooze sequencing; disarming overrides every other transition.
    always_comb begin
        al_st_d = al_st_q;
        cnt_d   = cnt_q;
        if (!alarm_on) begin
            al_st_d = A_IDLE;
            cnt_d   = '0;
        end else begin
            case (al_st_q)
                A_IDLE: begin
                    if (trig_s) begin
                        al_st_d = A_RING;
                        cnt_d   = RING_LD;
                    end else begin
                        al_st_d = A_IDLE;
                    end
                end
                A_RING: begin
                    if (stop_ev_s) begin
                        al_st_d = A_IDLE;
                        cnt_d   = '0;
                    end else if (snooze_ev_s) begin
                        al_st_d = A_SNOOZE;
                        cnt_d   = SNOOZE_LD;
                    end else if (cnt_q <= CNT_W'(1)) begin
                        al_st_d = A_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                    end
                end
                A_SNOOZE: begin
                    if (stop_ev_s) begin
                        al_st_d = A_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q <= CNT_W'(1)) begin
                        al_st_d = A_RING;
                        cnt_d   = RING_LD;
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    al_st_d = A_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        ringing_d = (al_st_d == A_RING);
    end

    // State and registered outputs; edge-detect history resets high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q       <= M_RUN;
            al_st_q      <= A_IDLE;
            key_q        <= 1'b1;
            hrup_q       <= 1'b0;
            minup_q      <= 1'b0;
            ringing_q    <= 1'b0;
            al_hr_q      <= 8'h00;
            al_min_q     <= 8'h00;
            cnt_q        <= '0;
            btn_prev_q   <= 4'b1111;
            match_prev_q <= 1'b1;
        end else begin
            mode_q       <= mode_d;
            al_st_q      <= al_st_d;
            key_q        <= key_d;
            hrup_q       <= hrup_d;
            minup_q      <= minup_d;
            ringing_q    <= ringing_d;
            al_hr_q      <= al_hr_d;
            al_min_q     <= al_min_d;
            cnt_q        <= cnt_d;
            btn_prev_q   <= btn_s;
            match_prev_q <= match_s;
        end
    end

    assign mode    = mode_q;
    assign key     = key_q;
    assign hrup    = hrup_q;
    assign minup   = minup_q;
    assign ringing = ringing_q;
    assign al_h2   = al_hr_q[7:4];
    assign al_h1   = al_hr_q[3:0];
    assign al_m2   = al_min_q[7:4];
    assign al_m1   = al_min_q[3:0];

endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Mode and alarm controller for the digital clock. Sits between the user pushbuttons and the `digClock` counter. Sequences the time-set modes by driving `digClock`'s `key`, `minup` and `hrup` inputs. Holds a BCD alarm time, compares it against the live `digClock` digits, and runs a ring/snooze sequence.

## Interface

Parameters:
- `RING_CYCLES`, default 60: number of `clk` cycles the alarm rings before it self-dismisses.
- `SNOOZE_CYCLES`, default 300: number of `clk` cycles of silence after a snooze.
- `CNT_W`, default 16: width of the ring/snooze down-counter. Both cycle parameters must be less than 2^CNT_W.

Ports:
- `clk`  in  1  system clock, the same clock as `digClock`.
- `reset`  in  1  synchronous, active-low reset.
- `mode_btn`  in  1  level input, already synchronised; a rising edge advances the mode.
- `inc_btn`  in  1  level input; a rising edge increments the field being set.
- `stop_btn`  in  1  level input; a rising edge dismisses the alarm.
- `snooze_btn`  in  1  level input; a rising edge snoozes the alarm.
- `alarm_on`  in  1  alarm arm switch.
- `h2`, `h1`, `m2`, `m1`, `s2`, `s1`  in  4 each  live BCD time from `digClock`.
- `key`  out  1  run enable to `digClock`; 1 = count.
- `hrup`  out  1  one-cycle hour-increment pulse to `digClock`.
- `minup`  out  1  one-cycle minute-increment pulse to `digClock`.
- `al_h2`, `al_h1`, `al_m2`, `al_m1`  out  4 each  alarm time, in BCD.
- `mode`  out  3  current main state encoding.
- `ringing`  out  1  alarm sounding.

## Operation

Edge detection:
- Each button has a previous-value register. An event is `btn & ~prev`.
- All previous-value registers load 1 during reset, so a button held through reset produces no event.

Main state machine (`mode` encoding):
- States: RUN=0, SET_HR=1, SET_MIN=2, AL_HR=3, AL_MIN=4.
- Each `mode_btn` event steps RUN→SET_HR→SET_MIN→AL_HR→AL_MIN→RUN.
- `key`=0 in SET_HR and SET_MIN; `key`=1 in all other states.
- `inc_btn` event, by state:
  - SET_HR: pulse `hrup`.
  - SET_MIN: pulse `minup`.
  - AL_HR: alarm hour +1, wrapping 23→00. BCD rule: `al_h1` 9→0 carries into `al_h2`.
  - AL_MIN: alarm minute +1, wrapping 59→00. BCD rule: `al_m1` 9→0 carries into `al_m2`.
  - RUN: ignored.
- A `mode_btn` event and an `inc_btn` event in the same cycle: the mode step wins and the increment is dropped.

Alarm state machine:
- States: IDLE, RING, SNOOZE.
- Match condition: `alarm_on` & {h2,h1,m2,m1}=={al_h2,al_h1,al_m2,al_m1} & `s2`==0 & `s1`==0.
- Trigger: the rising edge of match, detected against a registered copy of match.
  - That register resets to 1, so no ring occurs at 00:00:00 immediately after reset.
  - A held match never retriggers.
- Trigger is honoured in IDLE only, in any main state.
- IDLE→RING on trigger; the counter loads `RING_CYCLES`.
- RING: `ringing`=1.
  - A `stop_btn` event → IDLE.
  - Otherwise a `snooze_btn` event → SNOOZE, with the counter loading `SNOOZE_CYCLES`. Stop has priority over snooze.
  - Otherwise the counter reaching expiry → IDLE.
- SNOOZE: `ringing`=0.
  - A `stop_btn` event → IDLE.
  - The counter reaching expiry → RING, with the counter reloading `RING_CYCLES`.
- `alarm_on`=0 forces IDLE from any state, with priority over all other alarm transitions.
- Editing the alarm time in AL_HR or AL_MIN does not alter the current alarm state.

## Timing

Reset values (`reset`=0 at a `clk` edge):
- `mode`=0, `key`=1, `hrup`=0, `minup`=0, `ringing`=0.
- Alarm time 00:00; alarm state IDLE; counter 0.

Latencies:
- All outputs are registered.
- A button first sampled high at edge n is acted on at edge n, so its effect is visible after edge n.
  - `hrup` / `minup` are high for exactly one cycle.
  - `mode` and `key` change in the same cycle.
- `ringing` rises one cycle after match is first sampled true.
- `ringing` stays high for exactly `RING_CYCLES` cycles when not interrupted.
- A snooze gives exactly `SNOOZE_CYCLES` low cycles, then `ringing` is high again.
- `stop_btn`, `alarm_on`=0 and `reset`: `ringing` is 0 in the next cycle.

## Test plan

1. **Mode cycling.** Stimulus: release reset, then 5 `mode_btn` pulses. Required: `mode` steps 1,2,3,4,0; `key`=0 only while `mode` is 1 or 2; a held button gives a single step.
2. **Time-set pulses.** Stimulus: in SET_HR, 3 `inc_btn` pulses. Required: three one-cycle `hrup` pulses and `minup`=0 throughout. Stimulus: `mode_btn` and `inc_btn` rising in the same cycle. Required: `mode`→2 with no pulse.
3. **Alarm edit.** Stimulus: in AL_HR, 31 increments from reset. Required: alarm hour reads 07. Stimulus: in AL_MIN, 61 increments. Required: alarm minute reads 01, and the 59→00 wrap is observed.
4. **Ring.** Setup: `RING_CYCLES`=4, alarm 00:01, `alarm_on`=1. Stimulus: drive time 00:01:00 and hold it. Required: `ringing` is 1 for exactly 4 cycles starting one cycle after the match, then 0 with no retrigger.
5. **Snooze and stop.** Setup: `SNOOZE_CYCLES`=3. Stimulus: `snooze_btn` in ring cycle 2. Required: `ringing` 0 for 3 cycles, then 1. Stimulus: `stop_btn` together with `snooze_btn`. Required: IDLE, `ringing`=0 the next cycle.
6. **Disarm and reset.** Stimulus: drop `alarm_on` mid-ring. Required: `ringing`=0 the next cycle. Stimulus: assert `reset` while in SNOOZE and in AL_MIN. Required: all reset values restored, and time 00:00:00 does not ring after release.
